// File: rtl/fft_spectrum_ctrl_if.sv
// FFT core source-side stream: one complex bin per accepted beat, framed by sop/eop.
// The core drives the beat fields; the spectrum controller returns ready.
interface fft_spectrum_ctrl_if #(
  parameter int DW = 16
);
  logic                 fft_src_valid;
  logic                 fft_src_sop;
  logic                 fft_src_eop;
  logic signed [DW-1:0] fft_src_real;
  logic signed [DW-1:0] fft_src_imag;
  logic [1:0]           fft_src_error;
  logic                 fft_src_ready;

  modport master (
    output fft_src_valid, fft_src_sop, fft_src_eop,
    output fft_src_real, fft_src_imag, fft_src_error,
    input  fft_src_ready
  );

  modport slave (
    input  fft_src_valid, fft_src_sop, fft_src_eop,
    input  fft_src_real, fft_src_imag, fft_src_error,
    output fft_src_ready
  );
endinterface

// File: rtl/fft_spectrum_ctrl.sv
// Captures 128-bin FFT output frames as exact |X|^2 into a ping-pong buffer and
// exposes the last completed frame through a registered read port.
module fft_spectrum_ctrl #(
  parameter int FFT_LEN = 128,
  parameter int DW      = 16,
  parameter int AW      = 7,
  parameter int MAG_W   = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  fft_spectrum_ctrl_if.slave src,
  input  logic [AW-1:0]    rd_addr,
  output logic [MAG_W-1:0] rd_data,
  output logic             bank_sel,
  output logic             frame_done,
  output logic             frame_err
);
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  localparam logic [AW-1:0] LAST_BIN = AW'(FFT_LEN - 1);

  state_t            state_reg;
  logic [AW-1:0]     bin_cnt_reg;
  logic              flush_cnt_reg;
  logic              ready_reg;
  logic              s1_valid_reg;
  logic [AW-1:0]     s1_addr_reg;
  logic [MAG_W-1:0]  re_sq_reg;
  logic [MAG_W-1:0]  im_sq_reg;
  logic              s2_valid_reg;
  logic [AW-1:0]     s2_addr_reg;
  logic [MAG_W-1:0]  s2_sum_reg;
  logic [MAG_W-1:0]  mem [2*FFT_LEN];

  logic                    accept;
  logic signed [MAG_W-1:0] re_ext;
  logic signed [MAG_W-1:0] im_ext;

  assign accept            = src.fft_src_valid & ready_reg;
  assign src.fft_src_ready = ready_reg;
  assign re_ext = {{(MAG_W-DW){src.fft_src_real[DW-1]}}, src.fft_src_real};
  assign im_ext = {{(MAG_W-DW){src.fft_src_imag[DW-1]}}, src.fft_src_imag};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      bin_cnt_reg   <= '0;
      flush_cnt_reg <= 1'b0;
      ready_reg     <= 1'b0;
      bank_sel      <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_addr_reg   <= '0;
    end else begin
      s1_valid_reg <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      ready_reg    <= 1'b1;
      case (state_reg)
        IDLE, CAPTURE: begin
          if (accept) begin
            if (src.fft_src_error != 2'b00) begin
              frame_err   <= 1'b1;
              state_reg   <= IDLE;
              bin_cnt_reg <= '0;
            end else if (src.fft_src_sop) begin
              if (src.fft_src_eop) begin
                frame_err <= 1'b1;
                state_reg <= IDLE;
              end else begin
                // A sop inside a frame abandons it and restarts at bin 0.
                frame_err    <= (state_reg == CAPTURE);
                s1_valid_reg <= 1'b1;
                s1_addr_reg  <= '0;
                bin_cnt_reg  <= AW'(1);
                state_reg    <= CAPTURE;
              end
            end else if (state_reg == CAPTURE) begin
              if (src.fft_src_eop && bin_cnt_reg == LAST_BIN) begin
                s1_valid_reg  <= 1'b1;
                s1_addr_reg   <= bin_cnt_reg;
                state_reg     <= FLUSH;
                ready_reg     <= 1'b0;
                flush_cnt_reg <= 1'b0;
              end else if (src.fft_src_eop || bin_cnt_reg == LAST_BIN) begin
                frame_err   <= 1'b1;
                state_reg   <= IDLE;
                bin_cnt_reg <= '0;
              end else begin
                s1_valid_reg <= 1'b1;
                s1_addr_reg  <= bin_cnt_reg;
                bin_cnt_reg  <= bin_cnt_reg + AW'(1);
              end
            end
          end
        end
        FLUSH: begin
          // Swap on the same edge that retires the last bin's write.
          if (flush_cnt_reg) begin
            bank_sel   <= ~bank_sel;
            frame_done <= 1'b1;
            state_reg  <= IDLE;
          end else begin
            flush_cnt_reg <= 1'b1;
            ready_reg     <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    re_sq_reg  <= re_ext * re_ext;
    im_sq_reg  <= im_ext * im_ext;
    s2_sum_reg <= re_sq_reg + im_sq_reg;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s2_valid_reg <= 1'b0;
      s2_addr_reg  <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_addr_reg  <= s1_addr_reg;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (s2_valid_reg)
      mem[{~bank_sel, s2_addr_reg}] <= s2_sum_reg;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      rd_data <= '0;
    else
      rd_data <= mem[{bank_sel, rd_addr}];
  end
endmodule

// File: tb/tb_fft_spectrum_ctrl.sv
// Self-checking bench for fft_spectrum_ctrl: frame-level model of the ping-pong
// spectrum buffer plus a background reader that continuously checks the readable bank.
module tb_fft_spectrum_ctrl;
  localparam int N = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic        bank_sel, frame_done, frame_err;

  always #5 clk = ~clk;

  fft_spectrum_ctrl_if #(.DW(16)) src ();

  fft_spectrum_ctrl #(.FFT_LEN(128), .DW(16), .AW(7), .MAG_W(32)) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .src       (src),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .bank_sel  (bank_sel),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  typedef struct {
    int                 bin;
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [31:0]        exp;
  } corner_t;

  int checks = 0, failures = 0;
  int bg_checks = 0, bg_fails = 0;
  int done_cnt = 0, err_cnt = 0;

  logic signed [15:0] f_re [N];
  logic signed [15:0] f_im [N];
  logic [31:0]        gold [2][N];
  int                 ref_bank = 0;

  bit          man_mode = 1'b1;
  logic [6:0]  man_addr = '0;
  logic [6:0]  bg_addr = '0;
  logic [31:0] bg_exp = '0;
  bit          bg_pend = 1'b0;
  bit          rd_chk_en = 1'b0;

  assign rd_addr = man_mode ? man_addr : bg_addr;

  function automatic logic [31:0] mag(input logic signed [15:0] re, input logic signed [15:0] im);
    longint r, i, s;
    r = re;
    i = im;
    s = r * r + i * i;
    return s[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  // Random reads of the readable bank, checked one cycle later against the model.
  always @(posedge clk) begin
    #2;
    if (bg_pend) begin
      bg_checks++;
      if (rd_data !== bg_exp) begin
        bg_fails++;
        $display("FAIL bg_read addr=%0d: got %0h expected %0h", bg_addr, rd_data, bg_exp);
      end
    end
    if (rd_chk_en) begin
      bg_addr = 7'($urandom_range(0, N - 1));
      bg_exp  = gold[ref_bank][bg_addr];
      bg_pend = 1'b1;
    end else begin
      bg_pend = 1'b0;
    end
  end

  task automatic idle(input int n);
    src.fft_src_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic bg_on();
    man_mode  = 1'b0;
    rd_chk_en = 1'b1;
  endtask

  task automatic bg_off();
    rd_chk_en = 1'b0;
    repeat (2) @(negedge clk);
    man_mode = 1'b1;
  endtask

  task automatic send_beat(input bit sop, input bit eop, input logic signed [15:0] re,
                           input logic signed [15:0] im, input logic [1:0] err);
    src.fft_src_valid = 1'b1;
    src.fft_src_sop   = sop;
    src.fft_src_eop   = eop;
    src.fft_src_real  = re;
    src.fft_src_imag  = im;
    src.fft_src_error = err;
    for (int w = 0; w < 40; w++) begin
      if (src.fft_src_ready === 1'b1) begin
        @(negedge clk);
        src.fft_src_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL beat_accept_timeout: ready stuck at %0b, required 1 within 40 cycles", src.fft_src_ready);
    src.fft_src_valid = 1'b0;
  endtask

  task automatic good_frame(input bit gaps, input string tag);
    int d0, e0, wb;
    d0 = done_cnt;
    e0 = err_cnt;
    wb = ref_bank ^ 1;
    for (int k = 0; k < N; k++) gold[wb][k] = mag(f_re[k], f_im[k]);
    for (int k = 0; k < N; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_beat(k == 0, k == N - 1, f_re[k], f_im[k], 2'b00);
    end
    chk({tag, " ready_low_1"}, 32'(src.fft_src_ready), 32'd0);
    @(negedge clk);
    chk({tag, " ready_low_2"}, 32'(src.fft_src_ready), 32'd0);
    ref_bank = wb;
    @(negedge clk);
    chk({tag, " ready_back"}, 32'(src.fft_src_ready), 32'd1);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd1);
    chk({tag, " bank_sel"}, 32'(bank_sel), 32'(ref_bank));
    @(negedge clk);
    chk({tag, " done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, " no_err"}, 32'(err_cnt - e0), 32'd0);
  endtask

  // kind 0: eop early at bin cut; kind 1: error code 2'b01 on bin cut of a full frame.
  task automatic bad_frame(input int kind, input int cut, input bit gaps, input string tag);
    int d0, e0, last;
    d0 = done_cnt;
    e0 = err_cnt;
    last = (kind == 0) ? cut : N - 1;
    for (int k = 0; k <= last; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_beat(k == 0, k == last, f_re[k], f_im[k], (kind == 1 && k == cut) ? 2'b01 : 2'b00);
    end
    idle(3);
    chk({tag, " err_once"}, 32'(err_cnt - e0), 32'd1);
    chk({tag, " no_done"}, 32'(done_cnt - d0), 32'd0);
    chk({tag, " bank_kept"}, 32'(bank_sel), 32'(ref_bank));
  endtask

  corner_t ctab [6];

  initial begin
    ctab[0] = '{5,   16'sh8000, 16'sh8000, 32'h8000_0000};
    ctab[1] = '{17,  16'sh7fff, 16'sh7fff, 32'h7ffe_0002};
    ctab[2] = '{40,  16'sh8000, 16'sh0000, 32'h4000_0000};
    ctab[3] = '{64,  16'sh0000, 16'sh0000, 32'h0000_0000};
    ctab[4] = '{99,  16'sh0001, 16'shffff, 32'd2};
    ctab[5] = '{127, -16'sd1234, 16'sd5678, 32'd33762440};

    rst = 1'b1;
    src.fft_src_valid = 1'b0;
    src.fft_src_sop   = 1'b0;
    src.fft_src_eop   = 1'b0;
    src.fft_src_real  = '0;
    src.fft_src_imag  = '0;
    src.fft_src_error = '0;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(src.fft_src_ready), 32'd0);
    chk("rst bank_sel", 32'(bank_sel), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(src.fft_src_ready), 32'd1);

    // 1: re=k, im=-k, contiguous
    for (int k = 0; k < N; k++) begin
      f_re[k] = 16'(k);
      f_im[k] = 16'(-k);
    end
    good_frame(1'b0, "t1");
    for (int k = 0; k < N; k++) begin
      man_addr = 7'(k);
      @(negedge clk);
      chk($sformatf("t1 bin%0d", k), rd_data, 32'(2 * k * k));
    end

    // 2: corner magnitudes from the table
    for (int k = 0; k < N; k++) begin
      f_re[k] = 16'(k);
      f_im[k] = 16'(-k);
    end
    for (int i = 0; i < 6; i++) begin
      f_re[ctab[i].bin] = ctab[i].re;
      f_im[ctab[i].bin] = ctab[i].im;
    end
    good_frame(1'b0, "t2");
    for (int i = 0; i < 6; i++) begin
      man_addr = 7'(ctab[i].bin);
      @(negedge clk);
      chk($sformatf("t2 corner bin%0d", ctab[i].bin), rd_data, ctab[i].exp);
    end
    bg_on();

    // 3: early eop at bin 63
    for (int k = 0; k < N; k++) begin
      f_re[k] = 16'($urandom);
      f_im[k] = 16'($urandom);
    end
    bad_frame(0, 63, 1'b0, "t3");

    // 4: stray beats in IDLE, then sop+eop together, then a valid frame
    begin
      int e0;
      e0 = err_cnt;
      for (int i = 0; i < 5; i++) send_beat(1'b0, i == 4, 16'($urandom), 16'($urandom), 2'b00);
      idle(2);
      chk("t4 stray_silent", 32'(err_cnt - e0), 32'd0);
      send_beat(1'b1, 1'b1, 16'sd1, 16'sd1, 2'b00);
      idle(2);
      chk("t4 sop_eop_err", 32'(err_cnt - e0), 32'd1);
    end
    good_frame(1'b1, "t4");

    // 5: reset at bin 40, then a full frame
    bg_off();
    for (int k = 0; k <= 40; k++) send_beat(k == 0, 1'b0, f_re[k], f_im[k], 2'b00);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 rst ready", 32'(src.fft_src_ready), 32'd0);
    chk("t5 rst bank_sel", 32'(bank_sel), 32'd0);
    chk("t5 rst frame_done", 32'(frame_done), 32'd0);
    chk("t5 rst rd_data", rd_data, 32'd0);
    rst = 1'b0;
    ref_bank = 0;
    @(negedge clk);
    chk("t5 ready_after_rst", 32'(src.fft_src_ready), 32'd1);
    for (int k = 0; k < N; k++) begin
      f_re[k] = 16'($urandom);
      f_im[k] = 16'($urandom);
    end
    good_frame(1'b0, "t5");
    bg_on();

    // 6: back-to-back random frames with gaps; some carry an error beat
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < N; k++) begin
        f_re[k] = 16'($urandom);
        f_im[k] = 16'($urandom);
      end
      if (f == 3 || $urandom_range(0, 3) == 0)
        bad_frame(1, $urandom_range(0, N - 1), 1'b1, $sformatf("t6 f%0d bad", f));
      else
        good_frame(1'b1, $sformatf("t6 f%0d", f));
    end
    idle(4);
    bg_off();

    checks   += bg_checks;
    failures += bg_fails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule
